// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - RV32 memory stage: req/ack data-memory access, store lane alignment, load extension, writeback register
module mem_access_stage #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] alu_in,
    input  logic [4:0]  rd_addr_in,
    input  logic [31:0] rs2_data_in,
    input  logic        wr_en_in,
    input  logic        str_en_in,
    input  logic        load_en_in,
    input  logic        sb_en_in,
    input  logic        sh_en_in,
    input  logic        sw_en_in,
    input  logic        lb_en_in,
    input  logic        lh_en_in,
    input  logic        lw_en_in,
    input  logic        lbu_en_in,
    input  logic        lhu_en_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic [31:0] wb_data_out,
    output logic [4:0]  rd_addr_out,
    output logic        wr_en_out,
    output logic        misalign_out,
    output logic        bus_err_out
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic          is_store, is_load, mem_op, word_op, half_op, misaligned;
    logic [3:0]    be_n;
    logic [31:0]   wdata_n;
    logic          cap_load, cap_wr_en, cap_lw, cap_lh, cap_lhu, cap_lb;
    logic [1:0]    cap_lane;
    logic [4:0]    cap_rd;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   load_fmt;

    // A store enable masks any load controls presented alongside it.
    always_comb begin
        is_store   = str_en_in & (sb_en_in | sh_en_in | sw_en_in);
        is_load    = !str_en_in & load_en_in & (lb_en_in | lh_en_in | lw_en_in | lbu_en_in | lhu_en_in);
        mem_op     = is_store | is_load;
        word_op    = is_store ? sw_en_in : lw_en_in;
        half_op    = is_store ? (!sw_en_in & sh_en_in) : (!lw_en_in & (lh_en_in | lhu_en_in));
        misaligned = (word_op & (alu_in[1:0] != 2'b00)) | (half_op & alu_in[0]);
        be_n       = 4'b0000;
        wdata_n    = rs2_data_in;
        if (is_store) begin
            if (sw_en_in) begin
                be_n = 4'b1111;
            end else if (sh_en_in) begin
                be_n    = alu_in[1] ? 4'b1100 : 4'b0011;
                wdata_n = {2{rs2_data_in[15:0]}};
            end else begin
                be_n    = 4'b0001 << alu_in[1:0];
                wdata_n = {4{rs2_data_in[7:0]}};
            end
        end
    end

    always_comb begin
        byte_sel = 8'(dmem_rdata >> {cap_lane, 3'b000});
        half_sel = cap_lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        if (cap_lw)       load_fmt = dmem_rdata;
        else if (cap_lh)  load_fmt = {{16{half_sel[15]}}, half_sel};
        else if (cap_lhu) load_fmt = {16'h0000, half_sel};
        else if (cap_lb)  load_fmt = {{24{byte_sel[7]}}, byte_sel};
        else              load_fmt = {24'h000000, byte_sel};
    end

    assign stall = !rst & (((state == IDLE) & mem_op & !misaligned) | (state == BUSY));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            count        <= '0;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_wdata   <= '0;
            dmem_be      <= '0;
            wb_data_out  <= '0;
            rd_addr_out  <= '0;
            wr_en_out    <= 1'b0;
            misalign_out <= 1'b0;
            bus_err_out  <= 1'b0;
            cap_load     <= 1'b0;
            cap_wr_en    <= 1'b0;
            cap_lw       <= 1'b0;
            cap_lh       <= 1'b0;
            cap_lhu      <= 1'b0;
            cap_lb       <= 1'b0;
            cap_lane     <= '0;
            cap_rd       <= '0;
        end else begin
            misalign_out <= 1'b0;
            bus_err_out  <= 1'b0;
            case (state)
                IDLE: begin
                    if (!mem_op) begin
                        wb_data_out <= alu_in;
                        rd_addr_out <= rd_addr_in;
                        wr_en_out   <= wr_en_in;
                    end else if (misaligned) begin
                        misalign_out <= 1'b1;
                        wr_en_out    <= 1'b0;
                    end else begin
                        state      <= BUSY;
                        count      <= '0;
                        dmem_req   <= 1'b1;
                        dmem_we    <= is_store;
                        dmem_addr  <= {alu_in[31:2], 2'b00};
                        dmem_wdata <= wdata_n;
                        dmem_be    <= be_n;
                        wr_en_out  <= 1'b0;
                        cap_load   <= is_load;
                        cap_wr_en  <= wr_en_in;
                        cap_rd     <= rd_addr_in;
                        cap_lane   <= alu_in[1:0];
                        cap_lw     <= lw_en_in;
                        cap_lh     <= !lw_en_in & lh_en_in;
                        cap_lhu    <= !lw_en_in & !lh_en_in & lhu_en_in;
                        cap_lb     <= !lw_en_in & !lh_en_in & !lhu_en_in & lb_en_in;
                    end
                end
                BUSY: begin
                    if (dmem_ack) begin
                        state    <= RESP;
                        dmem_req <= 1'b0;
                        if (cap_load) begin
                            wb_data_out <= load_fmt;
                            rd_addr_out <= cap_rd;
                            wr_en_out   <= cap_wr_en;
                        end else begin
                            wr_en_out <= 1'b0;
                        end
                    end else if (count == CW'(TIMEOUT)) begin
                        state       <= RESP;
                        dmem_req    <= 1'b0;
                        bus_err_out <= 1'b1;
                        wr_en_out   <= 1'b0;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    wr_en_out <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - randomized self-checking bench for mem_access_stage against a behavioural model
module tb_mem_access_stage;
    localparam int TO = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] alu_in, rs2_data_in, dmem_rdata;
    logic [4:0]  rd_addr_in;
    logic        wr_en_in, str_en_in, load_en_in, sb_en_in, sh_en_in, sw_en_in;
    logic        lb_en_in, lh_en_in, lw_en_in, lbu_en_in, lhu_en_in, dmem_ack;
    logic        dmem_req, dmem_we, stall, wr_en_out, misalign_out, bus_err_out;
    logic [31:0] dmem_addr, dmem_wdata, wb_data_out;
    logic [3:0]  dmem_be;
    logic [4:0]  rd_addr_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .alu_in(alu_in), .rd_addr_in(rd_addr_in), .rs2_data_in(rs2_data_in),
        .wr_en_in(wr_en_in), .str_en_in(str_en_in), .load_en_in(load_en_in),
        .sb_en_in(sb_en_in), .sh_en_in(sh_en_in), .sw_en_in(sw_en_in),
        .lb_en_in(lb_en_in), .lh_en_in(lh_en_in), .lw_en_in(lw_en_in), .lbu_en_in(lbu_en_in), .lhu_en_in(lhu_en_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .stall(stall), .wb_data_out(wb_data_out),
        .rd_addr_out(rd_addr_out), .wr_en_out(wr_en_out), .misalign_out(misalign_out), .bus_err_out(bus_err_out)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] rs2;
        logic [4:0]  rd;
        logic wr_en, str, ld, sb, sh, sw, lb, lh, lw, lbu, lhu;
    } op_t;

    // Reference model: 0 = ALU pass-through, 1 = store, 2 = load
    function automatic int op_kind(op_t o);
        if (o.str) return (o.sb | o.sh | o.sw) ? 1 : 0;
        if (o.ld && (o.lb | o.lh | o.lw | o.lbu | o.lhu)) return 2;
        return 0;
    endfunction

    function automatic int op_size(op_t o);
        if (op_kind(o) == 1) return o.sw ? 4 : (o.sh ? 2 : 1);
        return o.lw ? 4 : ((o.lh | o.lhu) ? 2 : 1);
    endfunction

    function automatic bit op_signed(op_t o);
        return !o.lw && (o.lh || (!o.lhu && o.lb));
    endfunction

    function automatic logic [3:0] exp_be(op_t o);
        int sz = op_size(o);
        int lane = int'(o.addr[1:0]);
        if (op_kind(o) != 1) return 4'b0000;
        return 4'(((1 << sz) - 1) << lane);
    endfunction

    function automatic logic [31:0] exp_wdata(op_t o);
        int sz = op_size(o);
        if (sz == 4) return o.rs2;
        if (sz == 2) return 32'(o.rs2[15:0]) * 32'h0001_0001;
        return 32'(o.rs2[7:0]) * 32'h0101_0101;
    endfunction

    function automatic logic [31:0] exp_load(op_t o, logic [31:0] rdata);
        int sz = op_size(o);
        int lane = int'(o.addr[1:0]);
        longint span, v;
        if (sz == 4) return rdata;
        span = longint'(1) << (8 * sz);
        v = (longint'(rdata) >> (8 * lane)) % span;
        if (op_signed(o) && v >= span / 2) v = v - span;
        return v[31:0];
    endfunction

    task automatic drive(input op_t o);
        alu_in = o.addr; rs2_data_in = o.rs2; rd_addr_in = o.rd; wr_en_in = o.wr_en;
        str_en_in = o.str; load_en_in = o.ld; sb_en_in = o.sb; sh_en_in = o.sh; sw_en_in = o.sw;
        lb_en_in = o.lb; lh_en_in = o.lh; lw_en_in = o.lw; lbu_en_in = o.lbu; lhu_en_in = o.lhu;
    endtask

    function automatic op_t rand_op();
        op_t o = '0;
        o.addr = $urandom; o.rs2 = $urandom; o.rd = 5'($urandom); o.wr_en = 1'($urandom);
        case ($urandom_range(0, 2))
            0: {o.sb, o.sh, o.sw, o.lb, o.lh, o.lw, o.lbu, o.lhu} = 8'($urandom);
            1: begin
                o.str = 1'b1;
                {o.sb, o.sh, o.sw} = 3'($urandom_range(1, 7));
                {o.ld, o.lb, o.lh, o.lw, o.lbu, o.lhu} = 6'($urandom);
            end
            default: begin
                o.ld = 1'b1;
                {o.lb, o.lh, o.lw, o.lbu, o.lhu} = 5'($urandom_range(1, 31));
            end
        endcase
        if ($urandom_range(0, 1) == 1) o.addr[1:0] = 2'b00;
        return o;
    endfunction

    // Issues one instruction and follows it to completion, checking every cycle against the model.
    task automatic run_op(input op_t o, input int ack_delay, input logic [31:0] rdata);
        int   kind = op_kind(o);
        int   sz = op_size(o);
        bit   mis = (kind != 0) && (int'(o.addr[1:0]) % sz != 0);
        bit   acked = 0;
        logic exp_st = (kind != 0) && !mis;
        @(negedge clk);
        drive(o); dmem_ack = 1'b0; #1;
        checks++; if (stall !== exp_st) begin errors++; $display("FAIL issue_stall got=%b exp=%b", stall, exp_st); end
        @(posedge clk);
        if (kind == 0 || mis) begin
            @(negedge clk); #1;
            checks++;
            if (kind == 0 && {wb_data_out, rd_addr_out, wr_en_out, misalign_out} !== {o.addr, o.rd, o.wr_en, 1'b0}) begin
                errors++; $display("FAIL passthru got=%h/%0d/%b exp=%h/%0d/%b", wb_data_out, rd_addr_out, wr_en_out, o.addr, o.rd, o.wr_en);
            end
            if (mis && {misalign_out, wr_en_out, dmem_req, stall} !== 4'b1000) begin
                errors++; $display("FAIL misalign got=mis%b wr%b req%b st%b exp=mis1 wr0 req0 st0", misalign_out, wr_en_out, dmem_req, stall);
            end
            drive('0);
            return;
        end
        for (int k = 0; k <= TO; k++) begin
            @(negedge clk); #1;
            checks++;
            if ({dmem_req, stall, dmem_we} !== {2'b11, kind == 1}) begin
                errors++; $display("FAIL busy_ctrl k=%0d got=req%b st%b we%b exp=req1 st1 we%b", k, dmem_req, stall, dmem_we, kind == 1);
            end
            checks++;
            if (dmem_addr !== {o.addr[31:2], 2'b00} || dmem_be !== exp_be(o) || (kind == 1 && dmem_wdata !== exp_wdata(o))) begin
                errors++; $display("FAIL busy_bus got=%h/%b/%h exp=%h/%b/%h", dmem_addr, dmem_be, dmem_wdata, {o.addr[31:2], 2'b00}, exp_be(o), exp_wdata(o));
            end
            dmem_ack = (k == ack_delay);
            dmem_rdata = dmem_ack ? rdata : $urandom;
            @(posedge clk);
            if (dmem_ack) begin acked = 1; break; end
        end
        @(negedge clk);
        dmem_ack = 1'b0;
        drive(rand_op());
        #1;
        checks++; if ({dmem_req, stall} !== 2'b00) begin errors++; $display("FAIL resp_ctrl got=req%b st%b exp=req0 st0", dmem_req, stall); end
        checks++;
        if (!acked) begin
            if ({bus_err_out, wr_en_out} !== 2'b10) begin errors++; $display("FAIL timeout got=err%b wr%b exp=err1 wr0", bus_err_out, wr_en_out); end
        end else if (kind == 2) begin
            if ({wb_data_out, rd_addr_out, wr_en_out, bus_err_out} !== {exp_load(o, rdata), o.rd, o.wr_en, 1'b0}) begin
                errors++; $display("FAIL load_wb got=%h/%0d/%b exp=%h/%0d/%b", wb_data_out, rd_addr_out, wr_en_out, exp_load(o, rdata), o.rd, o.wr_en);
            end
        end else if ({wr_en_out, bus_err_out} !== 2'b00) begin
            errors++; $display("FAIL store_wb got=wr%b err%b exp=wr0 err0", wr_en_out, bus_err_out);
        end
        @(negedge clk);
        drive('0); #1;
        checks++;
        if ({wr_en_out, bus_err_out, dmem_req, stall} !== 4'b0000) begin
            errors++; $display("FAIL after_resp got=wr%b err%b req%b st%b exp=all 0", wr_en_out, bus_err_out, dmem_req, stall);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; drive('0); dmem_ack = 1'b0; dmem_rdata = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, stall, wb_data_out, rd_addr_out, wr_en_out, misalign_out, bus_err_out} !== '0) begin
            errors++; $display("FAIL reset got=req%b wb=%h wr%b st%b exp=all 0", dmem_req, wb_data_out, wr_en_out, stall);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        op_t o;
        o = '0; o.addr = 32'h0000_1234; o.rd = 5'd5; o.wr_en = 1'b1;
        run_op(o, 0, 32'h0);
        o = '0; o.addr = 32'h0000_0103; o.rd = 5'd7; o.wr_en = 1'b1; o.ld = 1'b1; o.lb = 1'b1;
        run_op(o, 0, 32'h80FF_0000);
        checks++; if (wb_data_out !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_value got=%h exp=ffffff80", wb_data_out); end
        o = '0; o.addr = 32'h0000_0202; o.rs2 = 32'hDEAD_BEEF; o.str = 1'b1; o.sh = 1'b1; o.wr_en = 1'b1;
        run_op(o, 1, 32'h0);
        o = '0; o.addr = 32'h0000_0101; o.ld = 1'b1; o.lw = 1'b1; o.wr_en = 1'b1;
        run_op(o, 0, 32'h0);
    endtask

    task automatic test_timeout();
        op_t o = '0;
        o.addr = 32'h0000_0102; o.ld = 1'b1; o.lhu = 1'b1; o.wr_en = 1'b1; o.rd = 5'd3;
        run_op(o, TO + 10, 32'h0);
    endtask

    task automatic test_reset_busy();
        op_t o = '0;
        o.addr = 32'h0000_0400; o.ld = 1'b1; o.lw = 1'b1; o.wr_en = 1'b1; o.rd = 5'd9;
        @(negedge clk); drive(o);
        @(negedge clk); #1;
        checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL pre_rst_req got=%b exp=1", dmem_req); end
        rst = 1'b1; #1;
        checks++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, stall, wb_data_out, rd_addr_out, wr_en_out, misalign_out, bus_err_out} !== '0) begin
            errors++; $display("FAIL rst_busy got=req%b st%b wr%b addr=%h exp=all 0", dmem_req, stall, wr_en_out, dmem_addr);
        end
        @(negedge clk); rst = 1'b0; drive('0); dmem_ack = 1'b1;
        @(negedge clk); dmem_ack = 1'b0; #1;
        checks++;
        if ({dmem_req, wr_en_out, stall} !== 3'b000) begin errors++; $display("FAIL post_rst got=req%b wr%b st%b exp=0 0 0", dmem_req, wr_en_out, stall); end
        o = '0; o.addr = 32'hCAFE_0001; o.rd = 5'd12; o.wr_en = 1'b1;
        run_op(o, 0, 32'h0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) run_op(rand_op(), $urandom_range(0, 4), $urandom);
    endtask

    task automatic test_back_to_back();
        op_t prev, o;
        bit  have = 0;
        for (int i = 0; i < 12; i++) begin
            o = '0; o.addr = $urandom; o.rd = 5'($urandom); o.wr_en = 1'($urandom);
            @(negedge clk);
            if (have) begin
                checks++;
                if ({wb_data_out, rd_addr_out, wr_en_out} !== {prev.addr, prev.rd, prev.wr_en}) begin
                    errors++; $display("FAIL b2b i=%0d got=%h/%0d/%b exp=%h/%0d/%b", i, wb_data_out, rd_addr_out, wr_en_out, prev.addr, prev.rd, prev.wr_en);
                end
            end
            drive(o); #1;
            checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_stall i=%0d got=%b exp=0", i, stall); end
            prev = o; have = 1;
        end
        @(negedge clk); drive('0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_timeout();
        test_reset_busy();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
